// File: rtl/fp_accum_ctrl_pkg.sv
// Shared float type and helpers for the accumulation controller.
// Holds the IEEE-754 single layout plus operand screening helpers.
package fp_accum_ctrl_pkg;

    localparam int COUNT_W = 16;

    typedef struct packed {
        logic        sign;
        logic [7:0]  biased_exponent;
        logic [22:0] mantissa;
    } float_t;

    localparam float_t FLOAT_POS_ZERO = '0;

    // Inf/NaN (exponent all-ones) or subnormal (exponent zero, mantissa set)
    function automatic logic is_unsupported_float(input float_t x);
        logic exp_max;
        logic subnorm;
        exp_max = &x.biased_exponent;
        subnorm = (x.biased_exponent == '0) && (x.mantissa != '0);
        return exp_max || subnorm;
    endfunction

endpackage

// File: rtl/fp_accum_ctrl_if.sv
// Generic valid/ready float stream with a side flag and a count field.
// Used for element input (flag=last) and result output (flag=err).
interface fp_accum_ctrl_if
    import fp_accum_ctrl_pkg::*;
();

    logic               valid;
    logic               ready;
    float_t             data;
    logic               flag;
    logic [COUNT_W-1:0] count;

    modport master (
        output valid,
        output data,
        output flag,
        output count,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  flag,
        input  count,
        output ready
    );

endinterface

// File: rtl/fp_accum_ctrl.sv
// Streaming reduction controller wrapped around an external fp_add.
// One addition in flight; running sum starts at +0 for each vector.
module fp_accum_ctrl
    import fp_accum_ctrl_pkg::*;
#(
    parameter int CountWidth = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    output logic                  in_ready_o,
    input  logic                  in_valid_i,
    input  float_t                in_data_i,
    input  logic                  in_last_i,
    input  logic                  add_op_ready_i,
    output logic                  add_op_valid_o,
    output float_t                add_op_a_o,
    output float_t                add_op_b_o,
    output logic                  add_sum_ready_o,
    input  logic                  add_sum_valid_i,
    input  float_t                add_sum_data_i,
    input  logic                  out_ready_i,
    output logic                  out_valid_o,
    output float_t                out_data_o,
    output logic [CountWidth-1:0] out_count_o,
    output logic                  out_err_o
);

    typedef enum logic [1:0] {
        ACCEPT,
        ISSUE,
        WAIT_SUM,
        OUTPUT
    } state_e;

    state_e                state_q, state_d;
    float_t                acc_q, acc_d;
    float_t                elem_q, elem_d;
    logic                  last_q, last_d;
    logic [CountWidth-1:0] count_q, count_d;
    logic                  err_q, err_d;

    // Handshake strobes are flops so they read 0 while in reset.
    logic in_ready_q, in_ready_d;
    logic op_valid_q, op_valid_d;
    logic sum_ready_q, sum_ready_d;
    logic out_valid_q, out_valid_d;

    // Next-state, datapath updates and registered strobe decode
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        elem_d  = elem_q;
        last_d  = last_q;
        count_d = count_q;
        err_d   = err_q;

        unique case (state_q)
            ACCEPT: begin
                if (in_valid_i && in_ready_q) begin
                    elem_d = in_data_i;
                    last_d = in_last_i;
                    if (count_q != '1) begin
                        count_d = count_q + 1'b1;
                    end
                    err_d   = err_q | is_unsupported_float(in_data_i);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (add_op_ready_i && op_valid_q) begin
                    state_d = WAIT_SUM;
                end
            end
            WAIT_SUM: begin
                if (add_sum_valid_i && sum_ready_q) begin
                    acc_d   = add_sum_data_i;
                    err_d   = err_q | is_unsupported_float(add_sum_data_i);
                    state_d = last_q ? OUTPUT : ACCEPT;
                end
            end
            OUTPUT: begin
                if (out_ready_i && out_valid_q) begin
                    acc_d   = FLOAT_POS_ZERO;
                    count_d = '0;
                    err_d   = 1'b0;
                    state_d = ACCEPT;
                end
            end
            default: state_d = ACCEPT;
        endcase

        in_ready_d  = (state_d == ACCEPT);
        op_valid_d  = (state_d == ISSUE);
        sum_ready_d = (state_d == WAIT_SUM);
        out_valid_d = (state_d == OUTPUT);
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ACCEPT;
            acc_q       <= FLOAT_POS_ZERO;
            elem_q      <= FLOAT_POS_ZERO;
            last_q      <= 1'b0;
            count_q     <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            op_valid_q  <= 1'b0;
            sum_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            elem_q      <= elem_d;
            last_q      <= last_d;
            count_q     <= count_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            op_valid_q  <= op_valid_d;
            sum_ready_q <= sum_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready_o      = in_ready_q;
    assign add_op_valid_o  = op_valid_q;
    assign add_op_a_o      = acc_q;
    assign add_op_b_o      = elem_q;
    assign add_sum_ready_o = sum_ready_q;
    assign out_valid_o     = out_valid_q;
    assign out_data_o      = acc_q;
    assign out_count_o     = count_q;
    assign out_err_o       = err_q;

endmodule

// File: tb/tb_fp_accum_ctrl.sv
// Directed bench for fp_accum_ctrl; the bench plays the role of fp_add
// and returns hand-computed sums while checking the issued operands.
module tb_fp_accum_ctrl;
    import fp_accum_ctrl_pkg::*;

    logic   clk;
    logic   rst_ni;
    logic   op_ready;
    logic   op_valid;
    float_t op_a;
    float_t op_b;

    int checks;
    int fails;

    fp_accum_ctrl_if in_if ();
    fp_accum_ctrl_if sum_if ();
    fp_accum_ctrl_if out_if ();

    fp_accum_ctrl #(.CountWidth(COUNT_W)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .in_ready_o      (in_if.ready),
        .in_valid_i      (in_if.valid),
        .in_data_i       (in_if.data),
        .in_last_i       (in_if.flag),
        .add_op_ready_i  (op_ready),
        .add_op_valid_o  (op_valid),
        .add_op_a_o      (op_a),
        .add_op_b_o      (op_b),
        .add_sum_ready_o (sum_if.ready),
        .add_sum_valid_i (sum_if.valid),
        .add_sum_data_i  (sum_if.data),
        .out_ready_i     (out_if.ready),
        .out_valid_o     (out_if.valid),
        .out_data_o      (out_if.data),
        .out_count_o     (out_if.count),
        .out_err_o       (out_if.flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_elem(input logic [31:0] d, input logic l);
        int n;
        in_if.valid = 1'b1;
        in_if.data  = d;
        in_if.flag  = l;
        n = 0;
        while (!in_if.ready && n < 60) begin
            step();
            n++;
        end
        checks++;
        if (in_if.ready !== 1'b1) begin
            fails++;
            $display("FAIL in_accept: in_ready=%b required 1", in_if.ready);
        end
        step();
        in_if.valid = 1'b0;
        in_if.flag  = 1'b0;
    endtask

    task automatic do_add(input logic [31:0] ea, input logic [31:0] eb,
                          input logic [31:0] s, input int lat);
        int n;
        n = 0;
        while (!op_valid && n < 60) begin
            step();
            n++;
        end
        checks++;
        if (op_valid !== 1'b1) begin
            fails++;
            $display("FAIL op_valid_wait: got %b required 1", op_valid);
        end
        checks++;
        if (op_a !== ea) begin
            fails++;
            $display("FAIL op_a: got %h required %h", op_a, ea);
        end
        checks++;
        if (op_b !== eb) begin
            fails++;
            $display("FAIL op_b: got %h required %h", op_b, eb);
        end
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
        repeat (lat) step();
        sum_if.valid = 1'b1;
        sum_if.data  = s;
        n = 0;
        while (!sum_if.ready && n < 60) begin
            step();
            n++;
        end
        checks++;
        if (sum_if.ready !== 1'b1) begin
            fails++;
            $display("FAIL sum_ready_wait: got %b required 1", sum_if.ready);
        end
        step();
        sum_if.valid = 1'b0;
    endtask

    task automatic get_out(input logic [31:0] ed, input int ec,
                           input logic ee);
        int n;
        out_if.ready = 1'b1;
        n = 0;
        while (!out_if.valid && n < 60) begin
            step();
            n++;
        end
        checks++;
        if (out_if.valid !== 1'b1) begin
            fails++;
            $display("FAIL out_valid_wait: got %b required 1", out_if.valid);
        end
        checks++;
        if (out_if.data !== ed) begin
            fails++;
            $display("FAIL out_data: got %h required %h", out_if.data, ed);
        end
        checks++;
        if (out_if.count !== COUNT_W'(ec)) begin
            fails++;
            $display("FAIL out_count: got %0d required %0d",
                     out_if.count, ec);
        end
        checks++;
        if (out_if.flag !== ee) begin
            fails++;
            $display("FAIL out_err: got %b required %b", out_if.flag, ee);
        end
        step();
        out_if.ready = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        logic [31:0] v;
        v = {in_if.ready, op_valid, sum_if.ready, out_if.valid,
             out_if.flag, 27'd0};
        checks++;
        if (v !== 32'd0 || op_a !== 32'd0 || op_b !== 32'd0 ||
            out_if.data !== 32'd0 || out_if.count !== '0) begin
            fails++;
            $display("FAIL %s: strobes=%h a=%h b=%h data=%h cnt=%0d required 0",
                     tag, v, op_a, op_b, out_if.data, out_if.count);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #3;
        check_all_zero("reset_outputs");
        step();
        check_all_zero("reset_held");
        rst_ni = 1'b1;
        step();
        checks++;
        if (in_if.ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_accept: in_ready=%b required 1", in_if.ready);
        end
    endtask

    task automatic test_sum3();
        send_elem(32'h3F800000, 1'b0);
        do_add(32'h00000000, 32'h3F800000, 32'h3F800000, 2);
        send_elem(32'h40000000, 1'b0);
        do_add(32'h3F800000, 32'h40000000, 32'h40400000, 0);
        send_elem(32'h40400000, 1'b1);
        do_add(32'h40400000, 32'h40400000, 32'h40C00000, 3);
        get_out(32'h40C00000, 3, 1'b0);
    endtask

    task automatic test_single();
        send_elem(32'hBF800000, 1'b1);
        do_add(32'h00000000, 32'hBF800000, 32'hBF800000, 1);
        get_out(32'hBF800000, 1, 1'b0);
    endtask

    task automatic test_err();
        send_elem(32'h7F800000, 1'b0);
        do_add(32'h00000000, 32'h7F800000, 32'h7F800000, 1);
        send_elem(32'h3F800000, 1'b1);
        do_add(32'h7F800000, 32'h3F800000, 32'h7F800000, 1);
        get_out(32'h7F800000, 2, 1'b1);
        send_elem(32'h3F800000, 1'b1);
        do_add(32'h00000000, 32'h3F800000, 32'h3F800000, 1);
        get_out(32'h3F800000, 1, 1'b0);
        send_elem(32'h00000001, 1'b1);
        do_add(32'h00000000, 32'h00000001, 32'h00000001, 1);
        get_out(32'h00000001, 1, 1'b1);
    endtask

    task automatic test_neg_zero();
        send_elem(32'h80000000, 1'b1);
        do_add(32'h00000000, 32'h80000000, 32'h00000000, 1);
        get_out(32'h00000000, 1, 1'b0);
    endtask

    task automatic test_op_stall();
        int bad;
        send_elem(32'h40000000, 1'b1);
        sum_if.valid = 1'b1;
        sum_if.data  = 32'h12345678;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (op_valid !== 1'b1 || op_a !== 32'h0 ||
                op_b !== 32'h40000000 || in_if.ready !== 1'b0 ||
                sum_if.ready !== 1'b0) begin
                bad++;
            end
            step();
        end
        checks++;
        if (bad != 0) begin
            fails++;
            $display("FAIL op_stall: %0d unstable cycles required 0", bad);
        end
        sum_if.valid = 1'b0;
        do_add(32'h00000000, 32'h40000000, 32'h40000000, 1);
        get_out(32'h40000000, 1, 1'b0);
    endtask

    task automatic test_out_stall();
        int bad;
        send_elem(32'h3F800000, 1'b1);
        do_add(32'h00000000, 32'h3F800000, 32'h3F800000, 1);
        in_if.valid = 1'b1;
        in_if.data  = 32'h40400000;
        in_if.flag  = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_if.valid !== 1'b1 || out_if.data !== 32'h3F800000 ||
                in_if.ready !== 1'b0) begin
                bad++;
            end
            step();
        end
        checks++;
        if (bad != 0) begin
            fails++;
            $display("FAIL out_stall: %0d unstable cycles required 0", bad);
        end
        get_out(32'h3F800000, 1, 1'b0);
        send_elem(32'h40400000, 1'b1);
        do_add(32'h00000000, 32'h40400000, 32'h40400000, 1);
        get_out(32'h40400000, 1, 1'b0);
    endtask

    task automatic test_reset_mid();
        send_elem(32'h3F800000, 1'b0);
        do_add(32'h00000000, 32'h3F800000, 32'h3F800000, 0);
        send_elem(32'h40000000, 1'b0);
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
        checks++;
        if (sum_if.ready !== 1'b1) begin
            fails++;
            $display("FAIL wait_sum_entry: sum_ready=%b required 1",
                     sum_if.ready);
        end
        rst_ni = 1'b0;
        #1;
        check_all_zero("reset_mid");
        step();
        rst_ni = 1'b1;
        step();
        send_elem(32'h3FC00000, 1'b0);
        do_add(32'h00000000, 32'h3FC00000, 32'h3FC00000, 1);
        send_elem(32'h3FA00000, 1'b1);
        do_add(32'h3FC00000, 32'h3FA00000, 32'h40300000, 2);
        get_out(32'h40300000, 2, 1'b0);
    endtask

    initial begin
        checks       = 0;
        fails        = 0;
        rst_ni       = 1'b0;
        op_ready     = 1'b0;
        in_if.valid  = 1'b0;
        in_if.data   = '0;
        in_if.flag   = 1'b0;
        in_if.count  = '0;
        sum_if.valid = 1'b0;
        sum_if.data  = '0;
        sum_if.flag  = 1'b0;
        sum_if.count = '0;
        out_if.ready = 1'b0;
        test_reset();
        test_sum3();
        test_single();
        test_err();
        test_neg_zero();
        test_op_stall();
        test_out_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
